// File: rtl/mips_mem_pkg.sv
// Shared memory-port definitions: access size encodings, the SPI flash READ
// opcode, the flash reader state enum and small data-shaping helpers.
package mips_mem_pkg;

  localparam logic [1:0] ACCESS_BYTE = 2'd0;
  localparam logic [1:0] ACCESS_HALF = 2'd1;
  localparam logic [1:0] ACCESS_WORD = 2'd2;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } flash_state_e;

  // Index of the first data bit shifted in; size 3 is handled as a word.
  function automatic logic [4:0] data_last_bit(input logic [1:0] size);
    case (size)
      ACCESS_BYTE: return 5'd7;
      ACCESS_HALF: return 5'd15;
      default:     return 5'd31;
    endcase
  endfunction

  // Right-align and zero-extend the received bits for the given size.
  function automatic logic [31:0] align_rx(input logic [31:0] rx, input logic [1:0] size);
    case (size)
      ACCESS_BYTE: return {24'h0, rx[7:0]};
      ACCESS_HALF: return {16'h0, rx[15:0]};
      default:     return rx;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// Request/response bus of the flash reader together with the board-level
// SPI flash pins. The reader takes the slave view; the requester (and the
// flash device side) take the master view.
interface spi_flash_reader_if;
  import mips_mem_pkg::*;

  logic        enable;
  logic [23:0] addr;
  logic [1:0]  access_size;
  logic        busy;
  logic        valid;
  logic [31:0] dout;
  logic        flash_cs;
  logic        flash_sck;
  logic        flash_sdi;
  logic        flash_sdo;
  logic        flash_wp;
  logic        flash_hld;

  modport slave (
    input  enable, addr, access_size, flash_sdo,
    output busy, valid, dout, flash_cs, flash_sck, flash_sdi, flash_wp, flash_hld
  );

  modport master (
    output enable, addr, access_size, flash_sdo,
    input  busy, valid, dout, flash_cs, flash_sck, flash_sdi, flash_wp, flash_hld
  );

endinterface

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock divider: SCK toggles every CLK_DIV clk cycles while
// enabled and rests low otherwise. The tick strobes are high during the cycle
// whose closing edge raises or lowers SCK.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sck_q;
  logic          half_done;

  assign half_done   = en_i && (cnt_q == CNT_LAST);
  assign rise_tick_o = half_done && !sck_q;
  assign fall_tick_o = half_done && sck_q;
  assign sck_o       = sck_q;

  // Half-period counter; SCK toggles when it wraps, and is parked low when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Memory-style read responder for an SPI NOR flash: sends READ (0x03) plus a
// 24-bit address, shifts in 8/16/32 data bits and returns them right-aligned.
module spi_flash_reader
  import mips_mem_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input logic                clk,
  input logic                rst,
  spi_flash_reader_if.slave  bus
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(CLK_DIV - 1);

  flash_state_e  state_q;
  logic [31:0]   shift_q;
  logic [31:0]   rx_q;
  logic [4:0]    bitcnt_q;
  logic [1:0]    size_q;
  logic [DW-1:0] dly_q;
  logic          cs_q;
  logic          sdi_q;
  logic          busy_q;
  logic          valid_q;
  logic [31:0]   dout_q;

  logic sck_en;
  logic sck;
  logic rise_tick;
  logic fall_tick;

  assign sck_en = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (sck_en),
    .sck_o       (sck),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.dout      = dout_q;
  assign bus.flash_cs  = cs_q;
  assign bus.flash_sck = sck;
  assign bus.flash_sdi = sdi_q;
  assign bus.flash_wp  = 1'b1;
  assign bus.flash_hld = 1'b1;

  // Transaction FSM: accept, shift out command/address on SCK falls, sample data on SCK rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      rx_q     <= '0;
      bitcnt_q <= '0;
      size_q   <= ACCESS_BYTE;
      dly_q    <= '0;
      cs_q     <= 1'b1;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.enable) begin
            size_q   <= bus.access_size;
            shift_q  <= {FLASH_CMD_READ, bus.addr};
            sdi_q    <= FLASH_CMD_READ[7];
            bitcnt_q <= 5'd31;
            rx_q     <= '0;
            cs_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_CMD;
          end
        end
        // Command and address share one 32-bit count; CMD covers counts 31..24.
        ST_CMD, ST_ADDR: begin
          if (fall_tick) begin
            if (bitcnt_q == 5'd0) begin
              sdi_q    <= 1'b0;
              bitcnt_q <= data_last_bit(size_q);
              state_q  <= ST_DATA;
            end else begin
              shift_q  <= {shift_q[30:0], 1'b0};
              sdi_q    <= shift_q[30];
              bitcnt_q <= bitcnt_q - 5'd1;
              if (bitcnt_q == 5'd24) state_q <= ST_ADDR;
            end
          end
        end
        ST_DATA: begin
          if (rise_tick) rx_q <= {rx_q[30:0], bus.flash_sdo};
          if (fall_tick) begin
            if (bitcnt_q == 5'd0) begin
              cs_q    <= 1'b1;
              dout_q  <= align_rx(rx_q, size_q);
              valid_q <= 1'b1;
              dly_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              bitcnt_q <= bitcnt_q - 5'd1;
            end
          end
        end
        // Hold CS high for CLK_DIV cycles before another request can be taken.
        ST_DONE: begin
          if (dly_q == DLY_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            dly_q <= dly_q + DW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader (CLK_DIV=2) with a behavioural mode-0
// SPI NOR flash model answering READ commands from a small byte map.
module tb_spi_flash_reader;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_flash_reader_if bus();

  spi_flash_reader #(.CLK_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- flash model ----------------
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'hDE;
      24'h000011: return 8'hAD;
      24'h000012: return 8'hBE;
      24'h000013: return 8'hEF;
      24'hFFFFFF: return 8'h5A;
      24'h000000: return 8'hC3;
      default:    return 8'h00;
    endcase
  endfunction

  logic [31:0] m_in   = '0;
  int          m_bits = 0;
  logic [7:0]  m_cmd  = '0;
  logic [23:0] m_addr = '0;
  int          rise_cnt = 0;
  logic        sdo_m  = 1'b0;

  assign bus.flash_sdo = sdo_m;

  always @(posedge bus.flash_sck or posedge bus.flash_cs) begin
    if (bus.flash_cs === 1'b1) begin
      m_bits = 0;
    end else begin
      rise_cnt++;
      m_in = {m_in[30:0], bus.flash_sdi};
      m_bits++;
      if (m_bits == 32) begin
        m_cmd  = m_in[31:24];
        m_addr = m_in[23:0];
      end
    end
  end

  always @(negedge bus.flash_sck) begin : drv
    int k;
    logic [23:0] a;
    logic [7:0]  b;
    if (bus.flash_cs === 1'b0 && m_bits >= 32) begin
      k = m_bits - 32;
      a = m_addr + 24'(k / 8);
      b = mem_byte(a);
      sdo_m = b[7 - (k % 8)];
    end
  end

  // One read; cycle numbers count the accept edge as cycle 0.
  task automatic do_read(input logic [23:0] a, input logic [1:0] sz,
                         output logic [31:0] d, output int vcyc, output int bcyc,
                         output int npulse, output int nrise);
    int r0;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.addr = a;
    bus.access_size = sz;
    r0 = rise_cnt;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    vcyc = -1; bcyc = -1; npulse = 0; d = '0;
    for (int k = 1; k <= 2000 && bcyc < 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        npulse++;
        if (vcyc < 0) begin vcyc = k + 1; d = bus.dout; end
      end
      if (bus.busy === 1'b0) bcyc = k + 1;
    end
    nrise = rise_cnt - r0;
    check("read_timeout", 32'(bcyc < 0), 32'd0);
  endtask

  logic [31:0] d, v0, v1;
  int vc, bc, np, nr;
  int nval, run, cs_gap, vk1, vseen;
  bit saw_idle, restarted;

  initial begin
    bus.enable = 1'b0;
    bus.addr = '0;
    bus.access_size = ACCESS_BYTE;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_cs",    32'(bus.flash_cs),  32'd1);
    check("rst_sck",   32'(bus.flash_sck), 32'd0);
    check("rst_sdi",   32'(bus.flash_sdi), 32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_valid", 32'(bus.valid),     32'd0);
    check("rst_dout",  bus.dout,           32'h0);
    check("rst_wp",    32'(bus.flash_wp),  32'd1);
    check("rst_hld",   32'(bus.flash_hld), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Word read at 0x000010
    do_read(24'h000010, ACCESS_WORD, d, vc, bc, np, nr);
    check("word_dout",   d,           32'hDEADBEEF);
    check("word_vcyc",   32'(vc),     32'd257);
    check("word_bcyc",   32'(bc),     32'd259);
    check("word_pulses", 32'(np),     32'd1);
    check("word_rises",  32'(nr),     32'd64);
    check("word_cmd",    32'(m_cmd),  32'h03);
    check("word_addr",   32'(m_addr), 32'h000010);
    repeat (5) @(posedge clk);
    #1;
    check("dout_hold",  bus.dout,           32'hDEADBEEF);
    check("valid_idle", 32'(bus.valid),     32'd0);
    check("cs_idle",    32'(bus.flash_cs),  32'd1);

    // Byte read at 0x000013
    do_read(24'h000013, ACCESS_BYTE, d, vc, bc, np, nr);
    check("byte_dout",  d,           32'h000000EF);
    check("byte_vcyc",  32'(vc),     32'd161);
    check("byte_bcyc",  32'(bc),     32'd163);
    check("byte_rises", 32'(nr),     32'd40);
    check("byte_addr",  32'(m_addr), 32'h000013);

    // Half read across the top of the address space
    do_read(24'hFFFFFF, ACCESS_HALF, d, vc, bc, np, nr);
    check("half_dout",  d,       32'h00005AC3);
    check("half_vcyc",  32'(vc), 32'd193);
    check("half_rises", 32'(nr), 32'd48);

    // Enable held high: second request waits for busy to drop
    @(negedge clk);
    bus.enable = 1'b1;
    bus.addr = 24'h000010;
    bus.access_size = ACCESS_WORD;
    @(posedge clk);
    #1;
    check("held_busy_start", 32'(bus.busy), 32'd1);
    nval = 0; run = 0; cs_gap = -1; vk1 = -1; saw_idle = 0; restarted = 0;
    v0 = '0; v1 = '0;
    for (int k = 1; k <= 1200; k++) begin
      @(posedge clk);
      #1;
      if (k == 40) begin
        bus.addr = 24'h000000;
        bus.access_size = ACCESS_BYTE;
      end
      if (bus.valid === 1'b1) begin
        nval++;
        if (nval == 1) v0 = bus.dout;
        else begin v1 = bus.dout; vk1 = k; end
      end
      if (bus.busy === 1'b0 && nval == 1) saw_idle = 1;
      if (bus.flash_cs === 1'b1) run++;
      else begin
        if (run > 0 && nval >= 1 && !restarted) begin
          cs_gap = run;
          restarted = 1;
          check("held_idle_before_cmd", 32'(saw_idle), 32'd1);
          bus.enable = 1'b0;
        end
        run = 0;
      end
      if (nval >= 2 && bus.busy === 1'b0) break;
    end
    check("held_nval",     32'(nval),   32'd2);
    check("held_first",    v0,          32'hDEADBEEF);
    check("held_second",   v1,          32'h000000C3);
    check("held_cs_gap",   32'(cs_gap), 32'd3);
    check("held_vk1",      32'(vk1),    32'd419);

    // Reset in the middle of the address phase
    @(negedge clk);
    bus.enable = 1'b1;
    bus.addr = 24'h000010;
    bus.access_size = ACCESS_WORD;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    repeat (62) @(posedge clk);
    #1;
    check("mid_sck_high", 32'(bus.flash_sck), 32'd1);
    check("mid_cs_low",   32'(bus.flash_cs),  32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cs",    32'(bus.flash_cs),  32'd1);
    check("mid_rst_sck",   32'(bus.flash_sck), 32'd0);
    check("mid_rst_sdi",   32'(bus.flash_sdi), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    check("mid_rst_valid", 32'(bus.valid),     32'd0);
    check("mid_rst_dout",  bus.dout,           32'h0);
    vseen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.valid !== 1'b0) vseen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (bus.valid !== 1'b0) vseen++;
    end
    check("mid_no_valid", 32'(vseen), 32'd0);
    check("mid_idle_busy", 32'(bus.busy), 32'd0);
    do_read(24'h000010, ACCESS_WORD, d, vc, bc, np, nr);
    check("post_rst_dout",  d,       32'hDEADBEEF);
    check("post_rst_vcyc",  32'(vc), 32'd257);
    check("post_rst_rises", 32'(nr), 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Memory-style read responder that fetches instruction/data bytes from an external SPI NOR flash using the standard READ (0x03) command. It accepts the same `enable`/`addr`/`access_size`/`busy` request handshake that `fetch_unit` drives toward `memory`. It serialises command and address onto the flash pins and returns the assembled read data. It sits between the core's memory port and the board-level `flash_*` pins, and is the master end of the flash interface that `main_top` exposes.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles; legal range ≥ 1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  read request; sampled only in IDLE.
- `addr`  in  24  flash byte address; captured at accept.
- `access_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word; captured at accept.
- `busy`  out  1  high while a transaction is in progress (state ≠ IDLE).
- `valid`  out  1  one-cycle pulse when `dout` is updated.
- `dout`  out  32  read data, big-endian, right-aligned, zero-extended.
- `flash_cs`  out  1  chip select, active-low.
- `flash_sck`  out  1  SPI clock, mode 0 (idle low).
- `flash_sdi`  out  1  serial data into the flash (MOSI).
- `flash_sdo`  in  1  serial data from the flash (MISO).
- `flash_wp`, `flash_hld`  out  1 each  tied high (write-protect and hold inactive).

## Operation
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → DATA (8/16/32 bits) → DONE → IDLE.
- IDLE: `enable` high at a rising edge latches `addr` and `access_size`, then moves to CMD. `busy` and `flash_cs` low take effect from the next cycle.
- `enable` while busy is ignored; there is no queueing.
- Shift register loads {0x03, addr[23:0]} and shifts out MSB first.
- Bit counter runs 31..0 across CMD and ADDR, then N−1..0 in DATA, with N = 8/16/32.
- Each bit lasts 2·CLK_DIV cycles:
  - `flash_sdi` changes at bit start with SCK low.
  - SCK rises after CLK_DIV cycles.
  - `flash_sdo` is sampled into the receive register on the clk edge that raises SCK (DATA phase only).
  - SCK falls after a further CLK_DIV cycles.
- Receive register shifts left. The first received byte lands in the most significant used byte: word gives dout = {b0,b1,b2,b3}, half gives {16'h0,b0,b1}, byte gives {24'h0,b0}.
- DONE entry:
  - `flash_cs` goes high and SCK stays low.
  - `dout` is loaded and `valid` pulses for exactly that cycle.
  - The block stays in DONE for CLK_DIV cycles (CS-high deselect time), then returns to IDLE and `busy` drops.
- `dout` holds its value until the next DONE.
- Addresses need no alignment. Address wrap past 0xFFFFFF is the flash's behaviour; the block does not alter it.
- Reset, including mid-transaction: all outputs go to reset values immediately, state becomes IDLE, and no `valid` is produced.

## Timing
- Reset values:
  - `flash_cs`=1, `flash_sck`=0, `flash_sdi`=0
  - `busy`=0, `valid`=0, `dout`=0
  - `flash_wp`=1, `flash_hld`=1
- Accept edge = cycle 0. CMD begins at cycle 1.
- `valid` at cycle 1 + (32+N)·2·CLK_DIV.
- `busy` low from cycle 1 + (32+N)·2·CLK_DIV + CLK_DIV.
- With CLK_DIV=2:
  - word: valid at cycle 257, busy low at 259.
  - byte: valid at cycle 161.
- SCK rising edges per transaction: exactly 32+N.
- `flash_cs` minimum high time between transactions: CLK_DIV cycles.
- `flash_cs` returns high only at DONE entry or reset, never mid-bit.

## Structure
- Shared package `mips_mem_pkg` holds:
  - `ACCESS_BYTE`/`ACCESS_HALF`/`ACCESS_WORD` encodings, shared with `fetch_unit` and `memory`.
  - `FLASH_CMD_READ` = 8'h03.
  - the state enum.
- One sub-module, `spi_sck_gen`: the divider counter. It produces `sck`, plus one-cycle `rise_tick`/`fall_tick` strobes, and is enabled only outside IDLE/DONE.
- The FSM, shift/receive registers and bit counter stay in the top module.

## Test plan
- Bench uses a behavioural mode-0 SPI flash model. Byte offsets 0x10–0x13 are preloaded with DE AD BE EF; 0xFFFFFF = 0x5A; 0x000000 = 0xC3.
- Reset: assert `rst` at any cycle → all outputs at listed reset values in the same cycle, with no clk edge needed.
- Word read, addr 0x000010, CLK_DIV=2 → `flash_sdi` carries 03 00 00 10, `dout`=0xDEADBEEF, `valid` single pulse at cycle 257, `busy` low at cycle 259, 64 SCK rises.
- Byte read, addr 0x000013 → `dout`=0x000000EF, 40 SCK rises, `valid` at cycle 161.
- Half read, addr 0xFFFFFF → `dout`=0x00005AC3 (model wraps).
- `enable` held high continuously → the second transaction's CMD starts only after `busy` drops. `flash_cs` is high ≥ CLK_DIV cycles between transactions, and pulses during busy have no effect.
- Reset asserted during the ADDR phase → `flash_cs`=1 and `flash_sck`=0 immediately, no `valid`. A subsequent word read at 0x000010 returns 0xDEADBEEF normally.
